disp_hms: RTL and testbench
===========================

// Module: disp_hms
// PURPOSE
// - Reader side of the clock's BCD time digits. Takes HH:MM:SS as BCD digit pairs from the
//   hour/minute/second counters and drives a 6-digit multiplexed common-anode 7-segment display.
// - Scans one digit at a time and snapshots the time once per frame, so no torn readout appears.
// - Supports per-field blinking (time-set mode) and the colon decimal points.
// PARAMETERS
// - CLK_DIV      default 50000  clock cycles per digit slot; must be >= 2.
// - BLINK_FRAMES default 64     full frames per blink half-period.
// - BLANK_LZ     default 1      1 = blank the hour MSD when it is 0.
// PORTS
// - disp_clock     in   1  system clock; single clock domain.
// - disp_reset     in   1  asynchronous reset, active-high.
// - disp_h_msd     in   2  hour tens, BCD 0..2.
// - disp_h_lsd     in   4  hour units, BCD 0..9.
// - disp_m_msd     in   3  minute tens, BCD 0..5.
// - disp_m_lsd     in   4  minute units.
// - disp_s_msd     in   3  second tens.
// - disp_s_lsd     in   4  second units.
// - disp_blink     in   3  field blink mask: [2]=hour, [1]=min, [0]=sec.
// - disp_colon     in   1  1 = light the decimal points after the hour and minute units.
// - disp_anode     out  6  digit enables, active-low; bit i = slot i (0 = hour MSD, leftmost).
// - disp_seg       out  7  {g,f,e,d,c,b,a}, active-low.
// - disp_dp        out  1  decimal point, active-low.
// BEHAVIOUR
// - Reset state: prescaler=0, slot=0, blink phase=ON, snapshot=all zero.
//   Outputs are all 1: anode=6'h3F, seg=7'h7F, dp=1.
// - Prescaler: counts 0..CLK_DIV-1. tick = (count==CLK_DIV-1). It wraps to 0 on the same edge.
// - Slot counter: 0..5, advances on tick, wraps 5->0.
// - Snapshot: on a tick that wraps slot 5->0, all six digit inputs are captured. Every slot in a
//   frame displays the snapshot only. Input changes mid-frame are invisible until the next frame.
// - Ghost suppression: on the edge where tick=1, anode is driven to 6'h3F for exactly one cycle.
//   On the next edge, anode shows the new slot's enable and seg/dp show the new slot's data.
//   Latency from tick to a lit new digit is 2 edges. All outputs are registered.
// - Blink: a frame counter runs 0..BLINK_FRAMES-1 and advances at each frame wrap.
//   At its terminal count the blink phase toggles.
//   While phase=OFF, slots of masked fields keep their anode off (1); seg is don't-care.
//   When disp_blink is all 0, the phase still runs but has no effect.
// - Decode: 0..9 use standard patterns (0=7'h40, 1=7'h79, 8=7'h00). Any value >9 shows dash 7'h3F.
// - Leading-zero blank: if BLANK_LZ=1 and the snapshot hour MSD is 0, slot 0's anode stays off.
// - Colon: disp_dp=0 on slots 1 and 3 when disp_colon=1 (sampled live, not snapshotted).
//   Otherwise disp_dp=1.
// - Reset asserted mid-operation: immediately returns to the reset state asynchronously.
//   After release, the first tick comes CLK_DIV cycles later. Slot 0 then shows the all-zero
//   snapshot until the first frame wrap.
// STRUCTURE
// - Shared package relogio_pkg:
//   - typedef slot_t (logic [2:0]).
//   - Constants SEG_DASH=7'h3F and SEG_OFF=7'h7F.
//   - Array SEG_LUT[10] of active-low patterns.
//   - Field index constants F_HOUR/F_MIN/F_SEC.
// - One sub-module, bcd_to_7seg: 4-bit BCD in, 7-bit active-low out, dash for >9.
//   Purely combinational; instantiated once on the muxed slot digit.
// - Top contains: prescaler, slot counter, snapshot registers, blink frame counter/phase,
//   output registers.
// TESTING (CLK_DIV=4, BLINK_FRAMES=2 unless noted)
// - Reset: assert disp_reset mid-cycle -> outputs become anode=3F, seg=7F, dp=1 without a clock edge.
// - Scan order: time 12:34:56, colon=1 -> anode walks 3E,3D,3B,37,2F,1F with one 3F gap per slot.
//   seg walks 79,24,30,19,12,02; dp=0 only on slots 1 and 3.
// - Snapshot: change input 12:34:56 -> 23:59:59 while slot=3 -> rest of frame still shows 4,5,6.
//   The next frame shows 2,3,5,9,5,9.
// - Invalid/LZ: h_lsd=4'hB, h_msd=0, BLANK_LZ=1 -> slot 0 anode stays off; slot 1 seg=3F.
// - Blink: disp_blink=3'b010 -> slots 2,3 dark for 2 frames, lit for 2, repeating.
//   Slots 0,1,4,5 are always lit.
// - Reset mid-frame at slot 4 -> slot=0 and snapshot=0 on release.
//   First lit digit appears CLK_DIV+1 cycles after release.

Source files
------------

// File: rtl/relogio_pkg.sv
// relogio_pkg: shared types and 7-segment constants for the clock display path.
package relogio_pkg;
    typedef logic [2:0] slot_t;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_LUT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [1:0] F_HOUR = 2'd2;
    localparam logic [1:0] F_MIN = 2'd1;
    localparam logic [1:0] F_SEC = 2'd0;
    // Two display slots per field, left to right: hour, minute, second.
    function automatic logic [1:0] field_of(input slot_t s);
        return s < 3'd2 ? F_HOUR : s < 3'd4 ? F_MIN : F_SEC;
    endfunction
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: BCD digit to active-low {g..a} pattern, dash for non-decimal codes.
module bcd_to_7seg
    import relogio_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb seg = bcd > 4'd9 ? SEG_DASH : SEG_LUT[bcd];
endmodule

// File: rtl/disp_hms.sv
// disp_hms: scans a frame-snapshotted HH:MM:SS onto a 6-digit multiplexed common-anode display.
module disp_hms
    import relogio_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       disp_clock,
    input  logic       disp_reset,
    input  logic [1:0] disp_h_msd,
    input  logic [3:0] disp_h_lsd,
    input  logic [2:0] disp_m_msd,
    input  logic [3:0] disp_m_lsd,
    input  logic [2:0] disp_s_msd,
    input  logic [3:0] disp_s_lsd,
    input  logic [2:0] disp_blink,
    input  logic       disp_colon,
    output logic [5:0] disp_anode,
    output logic [6:0] disp_seg,
    output logic       disp_dp
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [CW-1:0] count;
    logic [FW-1:0] frame;
    slot_t slot;
    logic phase;
    logic [1:0] snap_h_msd;
    logic [3:0] snap_h_lsd, snap_m_lsd, snap_s_lsd;
    logic [2:0] snap_m_msd, snap_s_msd;
    logic tick, wrap, frame_end, lit;
    logic [3:0] digit;
    logic [6:0] seg_next;
    assign tick = count == CW'(CLK_DIV - 1);
    assign wrap = tick && slot == 3'd5;
    assign frame_end = frame == FW'(BLINK_FRAMES - 1);
    always_comb begin
        digit = slot == 3'd0 ? {2'b00, snap_h_msd} :
                slot == 3'd1 ? snap_h_lsd :
                slot == 3'd2 ? {1'b0, snap_m_msd} :
                slot == 3'd3 ? snap_m_lsd :
                slot == 3'd4 ? {1'b0, snap_s_msd} :
                slot == 3'd5 ? snap_s_lsd : 4'hF;
        lit = !(BLANK_LZ && slot == 3'd0 && snap_h_msd == 2'd0) &&
              (phase || !disp_blink[field_of(slot)]);
    end
    bcd_to_7seg u_dec (
        .bcd(digit),
        .seg(seg_next)
    );
    // The tick edge blanks every anode so the old digit never ghosts onto the new slot.
    always_ff @(posedge disp_clock or posedge disp_reset)
        if (disp_reset) begin
            count <= '0;
            slot <= '0;
            frame <= '0;
            phase <= 1'b1;
            snap_h_msd <= '0;
            snap_h_lsd <= '0;
            snap_m_msd <= '0;
            snap_m_lsd <= '0;
            snap_s_msd <= '0;
            snap_s_lsd <= '0;
            disp_anode <= 6'h3F;
            disp_seg <= SEG_OFF;
            disp_dp <= 1'b1;
        end else begin
            count <= tick ? '0 : count + CW'(1);
            if (tick)
                slot <= slot == 3'd5 ? 3'd0 : slot + 3'd1;
            if (wrap) begin
                snap_h_msd <= disp_h_msd;
                snap_h_lsd <= disp_h_lsd;
                snap_m_msd <= disp_m_msd;
                snap_m_lsd <= disp_m_lsd;
                snap_s_msd <= disp_s_msd;
                snap_s_lsd <= disp_s_lsd;
                frame <= frame_end ? '0 : frame + FW'(1);
                if (frame_end)
                    phase <= !phase;
            end
            disp_anode <= (tick || !lit) ? 6'h3F : ~(6'd1 << slot);
            disp_seg <= seg_next;
            disp_dp <= !(disp_colon && (slot == 3'd1 || slot == 3'd3));
        end
endmodule

// File: tb/tb_disp_hms.sv
// tb_disp_hms: scoreboard bench; expected per-slot outputs are queued when inputs change.
module tb_disp_hms;
    localparam int CD = 4;
    localparam int FR = 6 * CD;
    logic clk = 1'b0, rst = 1'b0;
    logic [1:0] h_msd;
    logic [3:0] h_lsd, m_lsd, s_lsd;
    logic [2:0] m_msd, s_msd, blink;
    logic colon;
    logic [5:0] anode;
    logic [6:0] seg;
    logic dp;
    always #5 clk = ~clk;
    disp_hms #(.CLK_DIV(CD), .BLINK_FRAMES(2), .BLANK_LZ(1'b1)) dut (
        .disp_clock(clk), .disp_reset(rst),
        .disp_h_msd(h_msd), .disp_h_lsd(h_lsd),
        .disp_m_msd(m_msd), .disp_m_lsd(m_lsd),
        .disp_s_msd(s_msd), .disp_s_lsd(s_lsd),
        .disp_blink(blink), .disp_colon(colon),
        .disp_anode(anode), .disp_seg(seg), .disp_dp(dp)
    );
    typedef struct {
        logic [5:0] anode;
        logic [6:0] seg;
        logic dp;
        bit lit;
    } exp_t;
    exp_t q[$];
    int n_chk = 0, n_err = 0, e = 0;
    logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int sd [10][6] = '{'{1, 2, 3, 4, 5, 6}, '{1, 2, 3, 4, 5, 6}, '{2, 3, 5, 9, 5, 9},
                       '{0, 11, 0, 0, 0, 0}, '{1, 2, 3, 4, 5, 6}, '{1, 2, 3, 4, 5, 6},
                       '{1, 2, 3, 4, 5, 6}, '{1, 2, 3, 4, 5, 6}, '{2, 1, 0, 9, 4, 7},
                       '{2, 1, 0, 9, 4, 7}};
    logic sc [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] sb [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic apply(input int k);
        h_msd = 2'(sd[k][0]);
        h_lsd = 4'(sd[k][1]);
        m_msd = 3'(sd[k][2]);
        m_lsd = 4'(sd[k][3]);
        s_msd = 3'(sd[k][4]);
        s_lsd = 4'(sd[k][5]);
        colon = sc[k];
        blink = sb[k];
    endtask
    task automatic push_frame(input int k, input bit zero, input bit on);
        int d [6];
        exp_t x;
        for (int i = 0; i < 6; i++) d[i] = zero ? 0 : sd[k][i];
        for (int i = 0; i < 6; i++) begin
            x.lit = !(i == 0 && d[0] == 0) && (on || !sb[k][2 - i / 2]);
            x.anode = x.lit ? ~(6'd1 << i) : 6'h3F;
            x.seg = d[i] > 9 ? 7'h3F : lut[d[i]];
            x.dp = !(sc[k] && (i == 1 || i == 3));
            q.push_back(x);
        end
    endtask
    task automatic wait_e(input int target);
        int n = 0;
        while (e != target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait", e, target);
    endtask
    always @(posedge clk or posedge rst)
        if (rst) e <= 0;
        else e <= e + 1;
    // Mid-slot sample checks the lit digit; the slot-boundary sample checks the ghost gap.
    always @(negedge clk)
        if (!rst && e > 0) begin
            if (e % CD == 2) begin
                if (q.size() == 0) chk("q_empty", 1, 0);
                else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("anode", anode, x.anode);
                    if (x.lit) chk("seg", seg, x.seg);
                    chk("dp", dp, x.dp);
                end
            end else if (e % CD == 0)
                chk("gap", anode, 6'h3F);
        end
    initial begin
        int n;
        apply(0);
        #1 rst = 1'b1;
        #1;
        chk("rst_anode", anode, 6'h3F);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        push_frame(0, 1'b1, 1'b1);
        @(negedge clk) rst = 1'b0;
        for (int f = 0; f < 9; f++) begin
            wait_e(FR * f + 15);
            apply(f + 1);
            push_frame(f + 1, 1'b0, ((f + 1) / 2) % 2 == 0);
        end
        wait_e(FR * 9 + 4 * 4 + 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_anode", anode, 6'h3F);
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_dp", dp, 1);
        q.delete();
        push_frame(9, 1'b1, 1'b1);
        @(negedge clk) rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (anode == 6'h3F && n < 20);
        chk("first_lit", n, CD + 1);
        wait_e(FR + 1);
        chk("q_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
